// File: rtl/cnt_sched_pkg.sv
// cnt_sched_pkg: shared constants for the CNT16 round-robin scheduler.
// FSM encodings, counter width, terminal count and the load-value helper.
package cnt_sched_pkg;

    localparam int              CNT_W = 16;
    localparam logic [CNT_W-1:0] TERM = 16'hFFFF;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // The counter runs up to TERM, so loading TERM-len gives exactly len enables.
    function automatic logic [CNT_W-1:0] load_value(input logic [CNT_W-1:0] delay);
        return TERM - delay;
    endfunction

endpackage

// File: rtl/cnt_rr_arb.sv
// cnt_rr_arb: combinational round-robin pick.
// Returns the first set request bit at or after ptr, wrapping at N.
module cnt_rr_arb #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        int pos;
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        win = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!any && req[pos]) begin
                any      = 1'b1;
                idx      = IW'(pos);
                win[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt16_sched.sv
// cnt16_sched: round-robin scheduler sharing one loadable 16-bit up-counter
// among N requesters. Each job loads TERM-LEN, counts to terminal, pulses done.
// Optional watchdog: define CNT_SCHED_WDOG_EN to abort a RUN that overstays
// LEN+WDOG_MAX cycles with an err pulse; otherwise err is tied to 0.
module cnt16_sched
    import cnt_sched_pkg::*;
#(
    parameter int N        = 4,
    parameter int WDOG_MAX = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [16*N-1:0]    len,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       done,
    output logic [N-1:0]       err,
    output logic               busy,
    output logic               cnt_ld,
    output logic [CNT_W-1:0]   cnt_data,
    output logic               cnt_en,
    input  logic [CNT_W-1:0]   cnt_dout,
    input  logic               cnt_cout
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [1:0]       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    own;
    logic [IW-1:0]    ptr_nxt;
    logic [N-1:0]     win;
    logic [IW-1:0]    widx;
    logic             wany;
    logic [CNT_W-1:0] len_sel;
    logic             owner_req;
    logic             wdog_trip;

    // The counter value itself is not needed: cout already flags terminal.
    logic unused_cnt;
    assign unused_cnt = ^{cnt_dout, 1'(WDOG_MAX)};

    cnt_rr_arb #(.N(N), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr),
        .win (win),
        .idx (widx),
        .any (wany)
    );

    assign len_sel   = len[CNT_W*widx +: CNT_W];
    assign owner_req = req[own];
    assign ptr_nxt   = (own == IW'(N-1)) ? '0 : own + 1'b1;

    // Count only while the owner still wants the counter and terminal is not reached.
    assign cnt_en = (state == S_RUN) & ~cnt_cout & owner_req & ~wdog_trip;

`ifdef CNT_SCHED_WDOG_EN
    logic [16:0]      wd;
    logic [CNT_W-1:0] len_q;

    // Trip once the RUN cycle count including this one exceeds LEN+WDOG_MAX.
    assign wdog_trip = (state == S_RUN) &&
                       ((32'(wd) + 32'd1) > (32'(len_q) + 32'(WDOG_MAX)));

    // Watchdog RUN-cycle counter, cleared in LOAD; LEN captured with the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd    <= '0;
            len_q <= '0;
        end else begin
            if (state == S_IDLE && wany) len_q <= len_sel;
            if (state == S_LOAD)         wd    <= '0;
            else if (state == S_RUN)     wd    <= wd + 17'd1;
        end
    end

    // One-cycle abort pulse to the owner when the watchdog fires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= '0;
        else      err <= (state == S_RUN && owner_req && !cnt_cout && wdog_trip) ? gnt : '0;
    end
`else
    assign wdog_trip = 1'b0;
    assign err       = '0;
`endif

    // Scheduler FSM; every output except cnt_en is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            own      <= '0;
            gnt      <= '0;
            done     <= '0;
            busy     <= 1'b0;
            cnt_ld   <= 1'b0;
            cnt_data <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees pre-edge values.
            cnt_ld <= 1'b0;
            done   <= '0;
            case (state)
                S_IDLE: begin
                    if (wany) begin
                        state    <= S_LOAD;
                        own      <= widx;
                        gnt      <= win;
                        busy     <= 1'b1;
                        cnt_ld   <= 1'b1;
                        cnt_data <= load_value(len_sel);
                    end
                end
                S_LOAD: begin
                    if (!owner_req) begin
                        state <= S_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= ptr_nxt;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!owner_req || (!cnt_cout && wdog_trip)) begin
                        state <= S_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= ptr_nxt;
                    end else if (cnt_cout) begin
                        state <= S_DONE;
                        done  <= gnt;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= ptr_nxt;
                end
            endcase
        end
    end

endmodule
